// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the serializer that feeds the 1-1-0-1 detector.
// IDLE_BIT lives here so detector-side benches agree on the line idle level.
package bit_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int   DEFAULT_WIDTH    = 8;
    localparam logic DEFAULT_IDLE_BIT = 1'b0;

endpackage

// File: rtl/bit_serializer_hold.sv
// One-entry holding buffer that lets the next word wait while the current one shifts.
// The parent never writes and reads it in the same cycle.
module bit_serializer_hold
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    logic [WIDTH-1:0] hold_d, hold_q;
    logic             hold_full_d, hold_full_q;

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (wr) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end else if (rd) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign dout = hold_q;
    assign full = hold_full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over load/ready, one bit per clock out on w.
// Outputs depend only on registers, so there is no path from load/data_in to any output.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             w,
    output logic             bit_valid,
    output logic             last_bit
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] sreg_d, sreg_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic             hold_wr, hold_rd, hold_full;
    logic [WIDTH-1:0] hold_dout;
    logic [WIDTH-1:0] sreg_shifted;
    logic             out_bit;

    bit_serializer_hold #(.WIDTH(WIDTH)) u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (hold_wr),
        .rd      (hold_rd),
        .din     (data_in),
        .dout    (hold_dout),
        .full    (hold_full)
    );

    // Shift toward whichever end drives w, zero-filling behind.
    assign sreg_shifted = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0}
                                           : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        hold_wr = 1'b0;
        hold_rd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    sreg_d  = data_in;
                    cnt_d   = CNT_FULL;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q > CNT_ONE) begin
                    sreg_d  = sreg_shifted;
                    cnt_d   = cnt_q - CNT_ONE;
                    hold_wr = load && !hold_full;
                end else if (hold_full) begin
                    sreg_d  = hold_dout;
                    cnt_d   = CNT_FULL;
                    hold_rd = 1'b1;
                end else if (load) begin
                    // Bypass: hold is empty, so the new word goes straight into the shifter.
                    sreg_d = data_in;
                    cnt_d  = CNT_FULL;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_bit   = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
    assign ready     = !hold_full;
    assign bit_valid = (state_q == ST_SHIFT);
    assign last_bit  = bit_valid && (cnt_q == CNT_ONE);
    assign w         = bit_valid ? out_bit : IDLE_BIT;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first instance for streaming/backpressure/reset,
// LSB-first instance for bit order.
module tb_bit_serializer;

    logic       clk;
    logic       reset_n;
    logic [7:0] data_in;
    logic       load;
    logic       ready, w, bit_valid, last_bit;

    logic [7:0] data2;
    logic       load2;
    logic       ready2, w2, bv2, lb2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q[$];
    logic [3:0] det_hist;
    int         det_hits;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .load      (load),
        .ready     (ready),
        .w         (w),
        .bit_valid (bit_valid),
        .last_bit  (last_bit)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_lsb (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data2),
        .load      (load2),
        .ready     (ready2),
        .w         (w2),
        .bit_valid (bv2),
        .last_bit  (lb2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 1-1-0-1 overlapping detector watching w.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            det_hist <= 4'b0;
        end else begin
            det_hist <= {det_hist[2:0], w};
            if ({det_hist[2:0], w} == 4'b1101) det_hits <= det_hits + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive_src();
        load    = (q.size() > 0);
        data_in = (q.size() > 0) ? q[0] : 8'h00;
    endtask

    // Source model: holds load/data until a transfer happens at the edge.
    task automatic tick();
        logic fire;
        fire = load && ready;
        @(posedge clk);
        #1;
        if (fire) void'(q.pop_front());
        drive_src();
    endtask

    task automatic capture(input int n, output logic [63:0] bits, output int nvalid,
                           output int gaps, output int first, output int nlast,
                           output logic [63:0] rdy);
        int last;
        bits = '0; rdy = '0; nvalid = 0; nlast = 0; first = -1; last = -1;
        for (int j = 0; j < n; j++) begin
            rdy = {rdy[62:0], ready};
            if (bit_valid) begin
                bits = {bits[62:0], w};
                nvalid++;
                if (first < 0) first = j;
                last = j;
            end
            if (last_bit) nlast++;
            tick();
        end
        gaps = (first < 0) ? 0 : (last - first + 1 - nvalid);
    endtask

    logic [63:0] bits, rdy;
    int          nvalid, gaps, first, nlast, hits0;
    logic [7:0]  exp_lsb;

    initial begin
        det_hits = 0;
        reset_n  = 1'b0;
        load     = 1'b0;
        data_in  = 8'h00;
        load2    = 1'b0;
        data2    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_w", 64'(w), 64'd0);
        check("rst_bit_valid", 64'(bit_valid), 64'd0);
        check("rst_last_bit", 64'(last_bit), 64'd0);
        check("rst_ready", 64'(ready), 64'd1);
        reset_n = 1'b1;
        tick();

        // 1: single word D0
        hits0 = det_hits;
        q.push_back(8'hD0); drive_src();
        capture(11, bits, nvalid, gaps, first, nlast, rdy);
        check("t1_bits", bits, 64'hD0);
        check("t1_nvalid", 64'(nvalid), 64'd8);
        check("t1_first_idx", 64'(first), 64'd1);
        check("t1_nlast", 64'(nlast), 64'd1);
        check("t1_idle_w", 64'(w), 64'd0);
        check("t1_det_hits", 64'(det_hits - hits0), 64'd1);

        // 2: back-to-back D0, B4
        q.push_back(8'hD0); q.push_back(8'hB4); drive_src();
        capture(20, bits, nvalid, gaps, first, nlast, rdy);
        check("t2_bits", bits, 64'hD0B4);
        check("t2_gaps", 64'(gaps), 64'd0);
        check("t2_ready_hist", rdy, 64'(20'b11_0000000_11111111111));

        // 3: three words offered continuously
        q.push_back(8'hD0); q.push_back(8'hB4); q.push_back(8'h3C); drive_src();
        capture(28, bits, nvalid, gaps, first, nlast, rdy);
        check("t3_bits", bits, 64'hD0B43C);
        check("t3_nvalid", 64'(nvalid), 64'd24);
        check("t3_gaps", 64'(gaps), 64'd0);
        check("t3_nlast", 64'(nlast), 64'd3);
        check("t3_queue_drained", 64'(q.size()), 64'd0);
        check("t3_ready_hist", rdy,
              64'(28'b11_0000000_1_0000000_11111111111));

        // 4: bypass load on the last-bit cycle
        q.push_back(8'hD0); drive_src();
        repeat (8) tick();
        check("t4_last_bit_cycle", 64'(last_bit), 64'd1);
        check("t4_ready_at_last", 64'(ready), 64'd1);
        q.push_back(8'hA5); drive_src();
        capture(12, bits, nvalid, gaps, first, nlast, rdy);
        check("t4_bits", bits, 64'(9'b0_10100101));
        check("t4_gaps", 64'(gaps), 64'd0);
        check("t4_ready_hist", rdy, 64'(12'hFFF));

        // 5: async reset mid-word with hold full
        q.push_back(8'hFF); q.push_back(8'hFF); drive_src();
        repeat (3) tick();
        check("t5_pre_bit_valid", 64'(bit_valid), 64'd1);
        check("t5_pre_ready", 64'(ready), 64'd0);
        q.delete(); drive_src();
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_w", 64'(w), 64'd0);
        check("t5_rst_bit_valid", 64'(bit_valid), 64'd0);
        check("t5_rst_ready", 64'(ready), 64'd1);
        #1;
        reset_n = 1'b1;
        capture(12, bits, nvalid, gaps, first, nlast, rdy);
        check("t5_no_residual", 64'(nvalid), 64'd0);

        // 6: LSB-first, 0B -> 1,1,0,1,0,0,0,0
        exp_lsb = 8'b11010000;
        data2 = 8'h0B; load2 = 1'b1;
        @(posedge clk); #1;
        load2 = 1'b0; data2 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t6_w_%0d", i), 64'(w2), 64'(exp_lsb[7-i]));
            check($sformatf("t6_lb_%0d", i), 64'(lb2), 64'(i == 7));
            @(posedge clk); #1;
        end
        check("t6_idle_bv", 64'(bv2), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
